// File: rtl/sa_rdata_router_if.sv
// R-channel bundle between the slave port and the per-master dispatchers.
// "slave" modport is the router side, "master" modport is the driving side.
interface sa_rdata_router_if #(
  parameter int MST_AMT    = 3,
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]         s_RDATA_i;
  logic                          s_RLAST_i;
  logic                          s_RVALID_i;
  logic                          s_RREADY_o;
  logic [DATA_WIDTH*MST_AMT-1:0] dsp_RDATA_o;
  logic [MST_AMT-1:0]            dsp_RLAST_o;
  logic [MST_AMT-1:0]            dsp_RVALID_o;
  logic [MST_AMT-1:0]            dsp_RREADY_i;

  modport slave (
    input  s_RDATA_i, s_RLAST_i, s_RVALID_i, dsp_RREADY_i,
    output s_RREADY_o, dsp_RDATA_o, dsp_RLAST_o, dsp_RVALID_o
  );

  modport master (
    output s_RDATA_i, s_RLAST_i, s_RVALID_i, dsp_RREADY_i,
    input  s_RREADY_o, dsp_RDATA_o, dsp_RLAST_o, dsp_RVALID_o
  );
endinterface

// File: rtl/sa_rdata_router.sv
// sa_rdata_router: routes slave read-data beats to the master that issued the
// matching AR, using an in-order {mst_id, AxLEN} FIFO and a one-beat output
// register. Optional feature macro: RLAST_CHECK_EN (sticky RLAST mismatch
// flag); when undefined rlast_err_o is tied low.
module sa_rdata_router #(
  parameter int MST_AMT          = 3,
  parameter int OUTSTANDING_AMT  = 8,
  parameter int MST_ID_W         = $clog2(MST_AMT),
  parameter int DATA_WIDTH       = 32,
  parameter int TRANS_DATA_LEN_W = 3
) (
  input  logic                        ACLK_i,
  input  logic                        ARESET_i,
  input  logic [MST_ID_W-1:0]         AR_mst_id_i,
  input  logic [TRANS_DATA_LEN_W-1:0] AR_AxLEN_i,
  input  logic                        AR_fifo_order_wr_en_i,
  output logic                        AR_stall_o,
  output logic                        rlast_err_o,
  sa_rdata_router_if.slave            r_bus
);

  localparam int PTR_W   = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;
  localparam int CNT_W   = $clog2(OUTSTANDING_AMT + 1);
  localparam int ENTRY_W = MST_ID_W + TRANS_DATA_LEN_W;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING_AMT - 1);

  typedef enum logic {IDLE, ROUTE} state_t;

  state_t                        state_reg, state_next;
  logic [ENTRY_W-1:0]            order_mem [OUTSTANDING_AMT];
  logic [PTR_W-1:0]              wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]              order_cnt_reg;
  logic                          order_full, order_empty;
  logic                          push, pop;
  logic [MST_ID_W-1:0]           head_id;
  logic [TRANS_DATA_LEN_W-1:0]   head_len;
  logic [TRANS_DATA_LEN_W-1:0]   beat_cnt_reg;
  logic                          beat_last;
  logic                          s_ready, s_hs;
  logic                          out_busy, out_taken;
  logic [MST_AMT-1:0]            head_sel;
  logic [MST_AMT-1:0]            out_valid_reg, out_last_reg;
  logic [DATA_WIDTH*MST_AMT-1:0] out_data_reg;

  // The head entry is read asynchronously so the next burst can be routed
  // in the same cycle the previous one pops (no bubble between bursts).
  assign {head_id, head_len} = order_mem[rd_ptr_reg];

  assign order_full  = (order_cnt_reg == CNT_W'(OUTSTANDING_AMT));
  assign order_empty = (order_cnt_reg == '0);
  assign AR_stall_o  = order_full;

  assign beat_last = (beat_cnt_reg == head_len);

  // Output register is one-hot, so "ready of the held target" is simply
  // the OR of valid & ready across masters.
  assign out_busy  = |out_valid_reg;
  assign out_taken = |(out_valid_reg & r_bus.dsp_RREADY_i);

  assign s_ready = ~order_empty & (state_reg == ROUTE) & (~out_busy | out_taken);
  assign s_hs    = r_bus.s_RVALID_i & s_ready;
  assign pop     = s_hs & beat_last;
  // A push at full is only accepted when a pop frees a slot in the same cycle.
  assign push    = AR_fifo_order_wr_en_i & (~order_full | pop);

  assign r_bus.s_RREADY_o   = s_ready;
  assign r_bus.dsp_RVALID_o = out_valid_reg;
  assign r_bus.dsp_RLAST_o  = out_last_reg;
  assign r_bus.dsp_RDATA_o  = out_data_reg;

  // One-hot decode of the head entry's master ID.
  generate
    for (genvar gi = 0; gi < MST_AMT; gi++) begin : g_sel
      assign head_sel[gi] = (head_id == MST_ID_W'(gi));
    end
  endgenerate

  // Order FIFO storage; contents need no reset, occupancy is tracked separately.
  always_ff @(posedge ACLK_i) begin
    if (push) begin
      order_mem[wr_ptr_reg] <= {AR_mst_id_i, AR_AxLEN_i};
    end
  end

  // Order FIFO pointers and occupancy.
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      order_cnt_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   order_cnt_reg <= order_cnt_reg + 1'b1;
        2'b01:   order_cnt_reg <= order_cnt_reg - 1'b1;
        default: order_cnt_reg <= order_cnt_reg;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: ROUTE while at least one burst is outstanding.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (push) begin
          state_next = ROUTE;
        end
      end
      ROUTE: begin
        if (pop && (order_cnt_reg == CNT_W'(1)) && !push) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Beat counter within the head burst; wraps on the last beat.
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      beat_cnt_reg <= '0;
    end else if (s_hs) begin
      beat_cnt_reg <= beat_last ? '0 : beat_cnt_reg + 1'b1;
    end
  end

  // Output valid/last: load on slave handshake, clear once dispatched.
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      out_valid_reg <= '0;
      out_last_reg  <= '0;
    end else if (s_hs) begin
      out_valid_reg <= head_sel;
      out_last_reg  <= beat_last ? head_sel : '0;
    end else if (out_taken) begin
      out_valid_reg <= '0;
      out_last_reg  <= '0;
    end
  end

  // Per-master data slices; only the targeted slice is overwritten.
  generate
    for (genvar gi = 0; gi < MST_AMT; gi++) begin : g_data
      always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
          out_data_reg[gi*DATA_WIDTH +: DATA_WIDTH] <= '0;
        end else if (s_hs && head_sel[gi]) begin
          out_data_reg[gi*DATA_WIDTH +: DATA_WIDTH] <= r_bus.s_RDATA_i;
        end
      end
    end
  endgenerate

`ifdef RLAST_CHECK_EN
  logic rlast_err_reg;

  // Sticky flag: slave RLAST disagreed with the counter-derived last beat.
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      rlast_err_reg <= 1'b0;
    end else if (s_hs && (r_bus.s_RLAST_i != beat_last)) begin
      rlast_err_reg <= 1'b1;
    end
  end

  assign rlast_err_o = rlast_err_reg;
`else
  logic unused_rlast;
  assign unused_rlast = r_bus.s_RLAST_i;
  assign rlast_err_o  = 1'b0;
`endif

endmodule
